// File: rtl/cache_set_lru_ctrl.sv
// cache_set_lru_ctrl
// Tag-side controller for an 8-way set-associative cache with true-LRU
// replacement. It takes one lookup at a time and compares the tag against all
// eight ways of the addressed set. A hit refreshes that set's 8x8 LRU matrix.
// A miss picks a victim (first invalid way, else the LRU way), runs a refill
// handshake with the line-fill engine, and then installs the tag. The data
// array is indexed externally using resp_way.
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-high reset
//   flush              invalidates every way and clears all LRU state (IDLE only)
//   req_valid/ready    lookup handshake; req_set/req_tag are the lookup address
//   resp_valid         one-cycle response strobe; resp_hit/resp_way hold until
//                      the next response
//   mem_req/set/tag    refill request, held stable until mem_ack
//   mem_ack            refill complete
//
// Optional build macro CACHE_STATS_EN adds saturating hit_count/miss_count
// outputs. Reset and flush clear both counters.
module cache_set_lru_ctrl #(
  parameter int SETS  = 4,
  parameter int SET_W = 2,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [2:0]       resp_way,
  output logic             mem_req,
  output logic [SET_W-1:0] mem_set,
  output logic [TAG_W-1:0] mem_tag,
  input  logic             mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESP} state_t;

  state_t           state_q;
  logic [SET_W-1:0] reqSet_q;
  logic [TAG_W-1:0] reqTag_q;
  logic [2:0]       victim_q;
  logic             respValid_q;
  logic             respHit_q;
  logic [2:0]       respWay_q;
  logic             memReq_q;
  logic [SET_W-1:0] memSet_q;
  logic [TAG_W-1:0] memTag_q;

  logic [7:0]       valid_q [SETS];
  logic [63:0]      lru_q   [SETS];
  logic [TAG_W-1:0] tags_q  [SETS][8];

  logic             hitFound;
  logic [2:0]       hitWay;
  logic [2:0]       victim_d;

`ifdef CACHE_STATS_EN
  logic [15:0]      hitCount_q;
  logic [15:0]      missCount_q;
`endif

  // Touch way w in one LRU matrix (row i lives in bits [8*i +: 8]): set row w
  // to all ones, then clear column w. Row w therefore ends as all ones except
  // its own diagonal bit, which marks w as the most recently used way.
  function automatic logic [63:0] lruTouch(input logic [63:0] m, input logic [2:0] w);
    logic [63:0] r;
    r = m;
    r[8*w +: 8] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      r[8*i + int'(w)] = 1'b0;
    end
    return r;
  endfunction

  // Tag compare and victim choice for the latched request. The loops scan
  // downward, so the lowest-index way wins any tie. An all-zero LRU row marks
  // the least recently used way.
  always_comb begin
    hitFound = 1'b0;
    hitWay   = 3'd0;
    for (int w = 7; w >= 0; w--) begin
      if (valid_q[reqSet_q][w] && (tags_q[reqSet_q][w] == reqTag_q)) begin
        hitFound = 1'b1;
        hitWay   = 3'(w);
      end
    end
    victim_d = 3'd0;
    if (&valid_q[reqSet_q]) begin
      for (int i = 7; i >= 0; i--) begin
        if (lru_q[reqSet_q][8*i +: 8] == 8'h00) begin
          victim_d = 3'(i);
        end
      end
    end else begin
      for (int w = 7; w >= 0; w--) begin
        if (!valid_q[reqSet_q][w]) begin
          victim_d = 3'(w);
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE) && !flush;
  assign resp_valid = respValid_q;
  assign resp_hit   = respHit_q;
  assign resp_way   = respWay_q;
  assign mem_req    = memReq_q;
  assign mem_set    = memSet_q;
  assign mem_tag    = memTag_q;
`ifdef CACHE_STATS_EN
  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

  // Main controller: the state machine plus its registered outputs, the valid
  // bits, and the LRU matrices. Reset drops any operation in flight and sends
  // no response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      reqSet_q    <= '0;
      reqTag_q    <= '0;
      victim_q    <= 3'd0;
      respValid_q <= 1'b0;
      respHit_q   <= 1'b0;
      respWay_q   <= 3'd0;
      memReq_q    <= 1'b0;
      memSet_q    <= '0;
      memTag_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 8'h00;
        lru_q[s]   <= 64'h0;
      end
`ifdef CACHE_STATS_EN
      hitCount_q  <= 16'h0;
      missCount_q <= 16'h0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              valid_q[s] <= 8'h00;
              lru_q[s]   <= 64'h0;
            end
`ifdef CACHE_STATS_EN
            hitCount_q  <= 16'h0;
            missCount_q <= 16'h0;
`endif
          end else if (req_valid) begin
            reqSet_q <= req_set;
            reqTag_q <= req_tag;
            state_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hitFound) begin
            lru_q[reqSet_q] <= lruTouch(lru_q[reqSet_q], hitWay);
            respHit_q       <= 1'b1;
            respWay_q       <= hitWay;
            respValid_q     <= 1'b1;
`ifdef CACHE_STATS_EN
            if (hitCount_q != 16'hFFFF) begin
              hitCount_q <= hitCount_q + 16'd1;
            end
`endif
            state_q         <= RESP;
          end else begin
            victim_q <= victim_d;
            memReq_q <= 1'b1;
            memSet_q <= reqSet_q;
            memTag_q <= reqTag_q;
            state_q  <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid_q[reqSet_q][victim_q] <= 1'b1;
            lru_q[reqSet_q]             <= lruTouch(lru_q[reqSet_q], victim_q);
            memReq_q                    <= 1'b0;
            respHit_q                   <= 1'b0;
            respWay_q                   <= victim_q;
            respValid_q                 <= 1'b1;
`ifdef CACHE_STATS_EN
            if (missCount_q != 16'hFFFF) begin
              missCount_q <= missCount_q + 16'd1;
            end
`endif
            state_q                     <= RESP;
          end
        end
        RESP: begin
          respValid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag storage is kept out of reset because the valid bits qualify it. The
  // tag is written on the same edge that the refill completes.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == REFILL) && mem_ack) begin
      tags_q[reqSet_q][victim_q] <= reqTag_q;
    end
  end

endmodule

// File: tb/tb_cache_set_lru_ctrl.sv
// Testbench for cache_set_lru_ctrl. Stimulus predicts every response through a
// timestamp-based LRU reference model and queues the prediction. Monitor
// processes pop the queues and compare whenever the DUT presents a response or
// a refill request.
module tb_cache_set_lru_ctrl;

  localparam int SETS  = 4;
  localparam int SET_W = 2;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_hit;
  logic [2:0]       resp_way;
  logic             mem_req;
  logic [SET_W-1:0] mem_set;
  logic [TAG_W-1:0] mem_tag;
  logic             mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;
`endif

  always #5 clk = ~clk;

  cache_set_lru_ctrl #(.SETS(SETS), .SET_W(SET_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req(mem_req), .mem_set(mem_set), .mem_tag(mem_tag), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit       hit;
    logic [2:0] way;
    time      t;
  } exp_t;

  typedef struct {
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
  } refill_t;

  exp_t    expQ[$];
  refill_t memQ[$];

  int applied     = 0;
  int miscompares = 0;
  int ackDelay    = 2;
  bit ackHold     = 0;

  bit               mValid [SETS][8];
  logic [TAG_W-1:0] mTag   [SETS][8];
  longint           mStamp [SETS][8];
  longint           useCnt;
  int               mHits;
  int               mMisses;

  // Shared comparison point: every check goes through here and is counted.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 8; w++) begin
        mValid[s][w] = 0;
        mTag[s][w]   = '0;
        mStamp[s][w] = 0;
      end
    end
    useCnt  = 0;
    mHits   = 0;
    mMisses = 0;
  endfunction

  // Reference behaviour: hit on the first matching valid way. Otherwise fill
  // the first empty way, or else evict the way whose last use is oldest.
  function automatic void modelLookup(input int s, input logic [TAG_W-1:0] t,
                                      output bit hit, output logic [2:0] way);
    bit     found;
    longint best;
    hit = 0;
    way = 3'd0;
    for (int w = 0; w < 8; w++) begin
      if (mValid[s][w] && mTag[s][w] == t) begin
        hit = 1;
        way = 3'(w);
        break;
      end
    end
    if (!hit) begin
      found = 0;
      for (int w = 0; w < 8; w++) begin
        if (!mValid[s][w]) begin
          way   = 3'(w);
          found = 1;
          break;
        end
      end
      if (!found) begin
        best = 64'h7FFFFFFFFFFFFFFF;
        for (int w = 0; w < 8; w++) begin
          if (mStamp[s][w] < best) begin
            best = mStamp[s][w];
            way  = 3'(w);
          end
        end
      end
      mValid[s][way] = 1;
      mTag[s][way]   = t;
      mMisses++;
    end else begin
      mHits++;
    end
    useCnt++;
    mStamp[s][way] = useCnt;
  endfunction

  task automatic waitReady();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("req_ready timeout", 32'(req_ready), 32'd1);
  endtask

  // Issue one lookup and queue its predicted response, plus a predicted
  // refill request when the model expects a miss.
  task automatic applyStimulus(input int s, input logic [TAG_W-1:0] t);
    exp_t    e;
    refill_t r;
    bit      h;
    logic [2:0] w;
    waitReady();
    if (!req_ready) return;
    req_valid = 1'b1;
    req_set   = SET_W'(s);
    req_tag   = t;
    modelLookup(s, t, h, w);
    e.hit = h;
    e.way = w;
    e.t   = $time;
    expQ.push_back(e);
    if (!h) begin
      r.set = SET_W'(s);
      r.tag = t;
      memQ.push_back(r);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic doFlush(input bit withReq);
    waitReady();
    flush     = 1'b1;
    req_valid = withReq;
    req_set   = 2'd1;
    req_tag   = 8'h10;
    #1;
    checkOutput("req_ready under flush", 32'(req_ready), 32'd0);
    modelReset();
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
`ifdef CACHE_STATS_EN
    checkOutput("hit_count after flush", 32'(hit_count), 32'd0);
    checkOutput("miss_count after flush", 32'(miss_count), 32'd0);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain pending responses", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected resp_valid", 32'(resp_valid), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_hit", 32'(resp_hit), 32'(e.hit));
          checkOutput("resp_way", 32'(resp_way), 32'(e.way));
          if (e.hit) checkOutput("hit latency", 32'($time - e.t), 32'd20);
        end
      end
    end
  end

  // Memory responder and refill-request monitor.
  initial begin
    int d;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !ackHold) begin
        if (memQ.size() == 0) begin
          checkOutput("unexpected mem_req", 32'(mem_req), 32'd0);
        end else begin
          checkOutput("mem_set", 32'(mem_set), 32'(memQ[0].set));
          checkOutput("mem_tag", 32'(mem_tag), 32'(memQ[0].tag));
        end
        d = (ackDelay >= 0) ? ackDelay : int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        if (!ackHold) begin
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
          if (memQ.size() != 0) memQ.delete(0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_set   = '0;
    req_tag   = '0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_hit", 32'(resp_hit), 32'd0);
    checkOutput("reset resp_way", 32'(resp_way), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_set", 32'(mem_set), 32'd0);
    checkOutput("reset mem_tag", 32'(mem_tag), 32'd0);
    reset = 1'b0;

    $display("[TB] cold fill of set 1");
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'h10 + i));
    drain();

    $display("[TB] hits and LRU victims");
    applyStimulus(1, 8'h10);
    applyStimulus(1, 8'h13);
    applyStimulus(1, 8'h20);
    applyStimulus(1, 8'h21);
    drain();

    $display("[TB] set isolation");
    for (int i = 0; i < 8; i++) applyStimulus(0, 8'(8'h10 + i));
    applyStimulus(2, 8'h10);
    applyStimulus(0, 8'h10);
    drain();

    $display("[TB] flush with simultaneous request");
    doFlush(1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1, 8'h10);
    drain();

    $display("[TB] reset during refill");
    ackHold = 1'b1;
    applyStimulus(3, 8'h55);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mem_req before reset", 32'(mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mem_req after reset", 32'(mem_req), 32'd0);
    checkOutput("req_ready after reset", 32'(req_ready), 32'd1);
    checkOutput("resp_valid after reset", 32'(resp_valid), 32'd0);
    reset = 1'b0;
    expQ.delete();
    memQ.delete();
    modelReset();
    ackHold = 1'b0;
    applyStimulus(3, 8'h55);
    drain();

    $display("[TB] randomized traffic");
    ackDelay = -1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        drain();
        doFlush(1'($urandom_range(0, 1)));
      end else begin
        applyStimulus(int'($urandom_range(0, SETS - 1)), 8'($urandom_range(0, 11)));
      end
    end
    drain();

`ifdef CACHE_STATS_EN
    checkOutput("hit_count", 32'(hit_count), 32'(mHits));
    checkOutput("miss_count", 32'(miss_count), 32'(mMisses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_set_lru_ctrl.md
Name: cache_set_lru_ctrl

Overview:
Tag-side controller for an 8-way set-associative cache with true-LRU replacement.
- Accepts lookup requests and compares the tag against all 8 ways of the addressed set.
- On a hit: updates the set's 8x8 LRU matrix.
- On a miss: selects a victim, first invalid way else LRU way, sequences a refill handshake to memory, then installs the tag.
- Sits between the core request port and the line-fill engine; the data array is indexed externally using resp_way.

Parameters:
SETS, 4, number of sets (power of 2, >=2)
SET_W, 2, log2(SETS)
TAG_W, 8, tag width in bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
flush  in  1  invalidate all ways and clear all LRU state (IDLE only)
req_valid  in  1  lookup request valid
req_ready  out  1  controller can accept request/flush
req_set  in  SET_W  set index
req_tag  in  TAG_W  tag
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  1 = hit, 0 = miss (refilled)
resp_way  out  3  way hit or way filled
mem_req  out  1  refill request, held until mem_ack
mem_set  out  SET_W  refill set index
mem_tag  out  TAG_W  refill tag
mem_ack  in  1  refill complete

Behaviour:
- State: per set, 8 tags, 8 valid bits, 8x8 LRU matrix M. Registered FSM with states IDLE, LOOKUP, REFILL, RESP.
- Reset: FSM=IDLE; all valid=0, all M=0; req_ready=1; resp_valid=0, resp_hit=0, resp_way=0; mem_req=0, mem_set=0, mem_tag=0. Reset mid-operation aborts immediately with the same values; no response is issued.
- req_ready=1 only in IDLE and when flush=0.
- IDLE:
  - flush=1: clear all valid and M bits; stay IDLE. Flush has priority over a simultaneous req_valid, and that request is not accepted.
  - req_valid && req_ready: latch set/tag; go LOOKUP.
- LOOKUP (1 cycle): hit = valid[w] && tag[w]==req_tag for some w. Multiple matches cannot occur; if they do, the lowest w wins.
  - Hit: LRU update on w; latch resp_hit=1, resp_way=w; go RESP.
  - Miss: victim = lowest-index invalid way. If all ways are valid, victim = LRU way = lowest i with row M[i] all zero. Latch victim; go REFILL.
- REFILL: mem_req=1, with mem_set/mem_tag driving the latched request, stable until ack.
  - mem_ack=1 in the same cycle: write tag, set valid[victim]=1, LRU update on victim, mem_req=0 next cycle, resp_hit=0, resp_way=victim; go RESP.
  - mem_ack outside REFILL is ignored.
- RESP: resp_valid=1 for exactly one cycle; go IDLE. resp_hit/resp_way hold their value until the next response.
- LRU update on way w: row M[w] <= 8'hFF, then column w <= 0 (so M[w][w]=0). This is the same-cycle composite. Only the addressed set is touched.
- Latency:
  - Hit: request accepted cycle N, resp_valid at N+2, req_ready high again at N+3.
  - Miss: mem_req high from N+2; resp_valid the cycle after mem_ack.
- Fresh set (M=0, all invalid): victims fill in order 0,1,...,7.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each hit response; miss_count increments on each miss response, both at the resp_valid cycle.
  - Both saturate at 16'hFFFF.
  - Both are cleared by reset and by flush.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold fill: after reset, 8 misses to set 1 with tags 0x10..0x17 and mem_ack 2 cycles after each mem_req -> resp_way 0..7 in order, resp_hit=0, mem_set=1, mem_tag matches each request.
- Hit/LRU: following cold fill, hit tags 0x10, 0x13 -> resp_hit=1, ways 0,3, resp_valid 2 cycles after acceptance. Then miss tag 0x20 -> victim way 1. Then miss tag 0x21 -> victim way 2.
- Set isolation: fill set 0 fully, then miss set 2 tag 0x10 -> victim way 0 of set 2; set 0 hits on 0x10 still return way 0.
- Flush: flush=1 with req_valid=1 in the same cycle -> req_ready=0 and no response. Next lookup of a previously cached tag -> miss, victim way 0.
- Reset mid-refill: assert reset while mem_req=1 -> next cycle mem_req=0, req_ready=1, no resp_valid. Next lookup of any tag misses into way 0.
- Stats (CACHE_STATS_EN): 3 hits + 2 misses -> hit_count=3, miss_count=2. After flush both read 0.
